// File: rtl/movimiento_tablero.sv
// movimiento_tablero: NxN sliding-tile move engine that compresses and merges one board line per clock.
// Define MOV_SPAWN_EN to add an LFSR-driven tile spawn after every move that changed the board.
module movimiento_tablero #(
    parameter int N       = 4,
    parameter int EXP_W   = 4,
    parameter int SCORE_W = 20
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [N*N*EXP_W-1:0] board_in,
    input  logic                 start,
    input  logic [2:0]           dir,
    output logic                 busy,
    output logic                 done,
    output logic                 moved,
    output logic [N*N*EXP_W-1:0] board_out,
    output logic [SCORE_W-1:0]   score
);
    localparam int LW     = (N > 1) ? $clog2(N) : 1;
    localparam int GAIN_W = (1 << EXP_W) + $clog2(N) + 1;
    localparam int SUM_W  = ((SCORE_W > GAIN_W) ? SCORE_W : GAIN_W) + 1;
    localparam logic [EXP_W-1:0] EXP_MAX   = '1;
    localparam logic [SUM_W-1:0] SCORE_MAX = SUM_W'({SCORE_W{1'b1}});

    localparam logic [2:0] DIR_LEFT  = 3'd1;
    localparam logic [2:0] DIR_RIGHT = 3'd2;
    localparam logic [2:0] DIR_UP    = 3'd3;
    localparam logic [2:0] DIR_DOWN  = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LINE,
`ifdef MOV_SPAWN_EN
        ST_SPAWN,
`endif
        ST_DONE
    } state_t;

    state_t state, state_nx;

    logic [EXP_W-1:0]   cells    [N][N];
    logic [EXP_W-1:0]   cells_nx [N][N];
    logic [2:0]         dir_q;
    logic [LW-1:0]      line_idx;
    logic [SCORE_W-1:0] score_q, score_nx;
    logic               moved_acc, moved_q, busy_q, busy_nx, done_q;

    logic [EXP_W-1:0]   ln   [N];
    logic [EXP_W-1:0]   comp [N+1];
    logic [EXP_W-1:0]   res  [N];
    logic [EXP_W-1:0]   merged;
    logic [GAIN_W-1:0]  gain;
    logic [SUM_W-1:0]   score_sum;
    logic               line_changed, last_line, dir_valid;

    assign dir_valid = (dir == DIR_LEFT) || (dir == DIR_RIGHT) || (dir == DIR_UP) || (dir == DIR_DOWN);
    assign last_line = (line_idx == LW'(N - 1));

    // Line datapath: ln is the active line in read order (leading end first),
    // comp is it with empties squeezed out, res is the merged result.
    always_comb begin
        int  cnt;
        int  o;
        logic skip;
        cnt          = 0;
        o            = 0;
        skip         = 1'b0;
        merged       = '0;
        gain         = '0;
        line_changed = 1'b0;
        for (int k = 0; k < N; k++) ln[k] = '0;
        for (int k = 0; k <= N; k++) comp[k] = '0;
        for (int k = 0; k < N; k++) res[k] = '0;

        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                case (dir_q)
                    DIR_LEFT:  if (line_idx == LW'(r)) ln[c] = cells[r][c];
                    DIR_RIGHT: if (line_idx == LW'(r)) ln[N-1-c] = cells[r][c];
                    DIR_UP:    if (line_idx == LW'(c)) ln[r] = cells[r][c];
                    DIR_DOWN:  if (line_idx == LW'(c)) ln[N-1-r] = cells[r][c];
                    default: ;
                endcase
            end
        end

        for (int k = 0; k < N; k++) begin
            if (ln[k] != '0) begin
                for (int j = 0; j < N; j++) if (j == cnt) comp[j] = ln[k];
                cnt++;
            end
        end

        // skip marks the partner of a merge so no tile takes part in two merges
        for (int k = 0; k < N; k++) begin
            if (skip) begin
                skip = 1'b0;
            end else if (comp[k] != '0) begin
                if ((comp[k] == comp[k+1]) && (comp[k] != EXP_MAX)) begin
                    merged = comp[k] + EXP_W'(1);
                    gain   = gain + (GAIN_W'(1) << merged);
                    skip   = 1'b1;
                end else begin
                    merged = comp[k];
                end
                for (int j = 0; j < N; j++) if (j == o) res[j] = merged;
                o++;
            end
        end

        for (int k = 0; k < N; k++) if (res[k] != ln[k]) line_changed = 1'b1;
    end

    always_comb begin
        score_sum = SUM_W'(score_q) + SUM_W'(gain);
        score_nx  = (score_sum > SCORE_MAX) ? '1 : score_sum[SCORE_W-1:0];
    end

`ifdef MOV_SPAWN_EN
    localparam int CW = $clog2(N * N);

    logic [15:0]   lfsr;
    logic [CW-1:0] spawn_idx;
    logic          spawn_hit;

    always_comb begin
        spawn_hit = 1'b0;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                if ((spawn_idx == CW'(r * N + c)) && (cells[r][c] == '0)) spawn_hit = 1'b1;
    end

    // Free-running LFSR; the spawn search starts at its value when the last line is written.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr      <= 16'hACE1;
            spawn_idx <= '0;
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            if (state == ST_LINE && last_line)
                spawn_idx <= CW'(lfsr % 16'(N * N));
            else if (state == ST_SPAWN)
                spawn_idx <= (spawn_idx == CW'(N * N - 1)) ? '0 : spawn_idx + CW'(1);
        end
    end

    assign busy_nx = (state == ST_LINE) || (state == ST_SPAWN);
`else
    assign busy_nx = (state == ST_LINE);
`endif

    always_comb begin
        state_nx = state;
        cells_nx = cells;
        case (state)
            ST_IDLE: begin
                if (load) begin
                    for (int r = 0; r < N; r++)
                        for (int c = 0; c < N; c++)
                            cells_nx[r][c] = board_in[(r*N+c)*EXP_W +: EXP_W];
                end else if (start) begin
                    state_nx = dir_valid ? ST_LINE : ST_DONE;
                end
            end
            ST_LINE: begin
                for (int r = 0; r < N; r++) begin
                    for (int c = 0; c < N; c++) begin
                        case (dir_q)
                            DIR_LEFT:  if (line_idx == LW'(r)) cells_nx[r][c] = res[c];
                            DIR_RIGHT: if (line_idx == LW'(r)) cells_nx[r][c] = res[N-1-c];
                            DIR_UP:    if (line_idx == LW'(c)) cells_nx[r][c] = res[r];
                            DIR_DOWN:  if (line_idx == LW'(c)) cells_nx[r][c] = res[N-1-r];
                            default: ;
                        endcase
                    end
                end
                if (last_line) begin
`ifdef MOV_SPAWN_EN
                    state_nx = (moved_acc || line_changed) ? ST_SPAWN : ST_DONE;
`else
                    state_nx = ST_DONE;
`endif
                end
            end
`ifdef MOV_SPAWN_EN
            ST_SPAWN: begin
                for (int r = 0; r < N; r++)
                    for (int c = 0; c < N; c++)
                        if ((spawn_idx == CW'(r * N + c)) && (cells[r][c] == '0))
                            cells_nx[r][c] = EXP_W'(1);
                if (spawn_hit) state_nx = ST_DONE;
            end
`endif
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // busy/done are registered from the current state, so they trail the FSM by one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cells     <= '{default: '0};
            dir_q     <= '0;
            line_idx  <= '0;
            score_q   <= '0;
            moved_acc <= 1'b0;
            moved_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state  <= state_nx;
            cells  <= cells_nx;
            busy_q <= busy_nx;
            done_q <= (state == ST_DONE);
            case (state)
                ST_IDLE: begin
                    if (load) begin
                        score_q <= '0;
                    end else if (start) begin
                        dir_q     <= dir;
                        line_idx  <= '0;
                        moved_acc <= 1'b0;
                    end
                end
                ST_LINE: begin
                    line_idx  <= line_idx + LW'(1);
                    score_q   <= score_nx;
                    moved_acc <= moved_acc | line_changed;
                end
                ST_DONE: moved_q <= moved_acc;
                default: ;
            endcase
        end
    end

    always_comb begin
        board_out = '0;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                board_out[(r*N+c)*EXP_W +: EXP_W] = cells[r][c];
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign moved = moved_q;
    assign score = score_q;

endmodule

// File: tb/tb_movimiento_tablero.sv
// Self-checking bench for movimiento_tablero: queue-based reference model of whole-line moves,
// checked every cycle, plus directed literal cases and randomized boards/directions.
module tb_movimiento_tablero;
    localparam int N       = 4;
    localparam int EXP_W   = 4;
    // Narrow score so a single loaded board can drive it into saturation.
    localparam int SCORE_W = 16;
    localparam int CELLS   = N * N;
    localparam int BW      = CELLS * EXP_W;
    localparam int EMAX    = (1 << EXP_W) - 1;
    localparam longint SMAX = (longint'(1) << SCORE_W) - 1;

    logic               clk = 1'b0;
    logic               rst, load, start;
    logic [2:0]         dir;
    logic [BW-1:0]      board_in, board_out;
    logic               busy, done, moved;
    logic [SCORE_W-1:0] score;

    movimiento_tablero #(.N(N), .EXP_W(EXP_W), .SCORE_W(SCORE_W)) dut (
        .clk(clk), .rst(rst), .load(load), .board_in(board_in), .start(start), .dir(dir),
        .busy(busy), .done(done), .moved(moved), .board_out(board_out), .score(score)
    );

    always #5 clk = ~clk;

    int     checks = 0;
    int     passes = 0;
    int     mb [N][N];
    longint mscore = 0;
    bit     mmoved = 0, exp_moved = 0, exp_busy = 0, exp_done = 0, check_en = 0;

    task automatic check_output(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got === want) passes++;
        else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, got, want);
    endtask

    function automatic int cell_at(input logic [BW-1:0] b, input int r, input int c);
        return int'(b[(r*N+c)*EXP_W +: EXP_W]);
    endfunction

    function automatic logic [BW-1:0] put(input logic [BW-1:0] b, input int r, input int c, input int v);
        b[(r*N+c)*EXP_W +: EXP_W] = EXP_W'(v);
        return b;
    endfunction

    function automatic logic [BW-1:0] model_board();
        logic [BW-1:0] b = '0;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) b = put(b, r, c, mb[r][c]);
        return b;
    endfunction

    // One line of a move: gather tiles in read order, merge pairs front to back, write back padded with 0.
    function automatic void model_line(input int d, input int i);
        int rr[N], cc[N];
        int q[$], outq[$];
        int a, nv;
        for (int k = 0; k < N; k++) begin
            case (d)
                1: begin rr[k] = i;         cc[k] = k;         end
                2: begin rr[k] = i;         cc[k] = N - 1 - k; end
                3: begin rr[k] = k;         cc[k] = i;         end
                default: begin rr[k] = N - 1 - k; cc[k] = i;   end
            endcase
            if (mb[rr[k]][cc[k]] != 0) q.push_back(mb[rr[k]][cc[k]]);
        end
        while (q.size() > 0) begin
            a = q.pop_front();
            if (q.size() > 0 && q[0] == a && a != EMAX) begin
                void'(q.pop_front());
                outq.push_back(a + 1);
                mscore += longint'(1) << (a + 1);
            end else begin
                outq.push_back(a);
            end
        end
        if (mscore > SMAX) mscore = SMAX;
        for (int k = 0; k < N; k++) begin
            nv = (k < outq.size()) ? outq[k] : 0;
            if (nv != mb[rr[k]][cc[k]]) mmoved = 1;
            mb[rr[k]][cc[k]] = nv;
        end
    endfunction

    // Single compare process: every cycle the DUT must match the model.
    always @(negedge clk) begin
        if (check_en) begin
            check_output("busy",  64'(busy),      64'(exp_busy));
            check_output("done",  64'(done),      64'(exp_done));
            check_output("moved", 64'(moved),     64'(exp_moved));
            check_output("score", 64'(score),     64'(mscore));
            check_output("board", 64'(board_out), 64'(model_board()));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic noise();
        start    = 1'($urandom);
        load     = 1'($urandom);
        dir      = 3'($urandom);
        board_in = BW'({$urandom, $urandom});
    endtask

    task automatic do_load(input logic [BW-1:0] b);
        board_in = b;
        load     = 1'b1;
        start    = 1'b0;
        step();
        load = 1'b0;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) mb[r][c] = cell_at(b, r, c);
        mscore = 0;
    endtask

    task automatic apply_stimulus(input int d);
        start = 1'b1;
        dir   = 3'(d);
        load  = 1'b0;
        step();
        mmoved = 0;
        noise();
        if (d >= 1 && d <= 4) begin
            for (int i = 0; i < N; i++) begin
                step();
                model_line(d, i);
                exp_busy = 1;
                noise();
            end
`ifdef MOV_SPAWN_EN
            if (mmoved) begin
                int guard, ndiff, nok, dv;
                check_en = 0;
                guard    = 0;
                while (!done && guard < CELLS + 2) begin
                    step();
                    guard++;
                end
                check_output("spawn_done", 64'(done), 64'd1);
                ndiff = 0;
                nok   = 0;
                for (int r = 0; r < N; r++) begin
                    for (int c = 0; c < N; c++) begin
                        dv = cell_at(board_out, r, c);
                        if (dv != mb[r][c]) begin
                            ndiff++;
                            if (mb[r][c] == 0 && dv == 1) nok++;
                            mb[r][c] = dv;
                        end
                    end
                end
                check_output("spawn_cells", 64'(ndiff), 64'd1);
                check_output("spawn_empty_to_1", 64'(nok), 64'd1);
                exp_busy  = 0;
                exp_done  = 1;
                exp_moved = 1;
                check_en  = 1;
            end else begin
                step();
                exp_busy  = 0;
                exp_done  = 1;
                exp_moved = mmoved;
            end
`else
            step();
            exp_busy  = 0;
            exp_done  = 1;
            exp_moved = mmoved;
`endif
        end else begin
            step();
            exp_done  = 1;
            exp_moved = 0;
        end
        start = 1'b0;
        load  = 1'b0;
        step();
        exp_done = 0;
    endtask

    task automatic check_vec(input string name, input int r, input int c, input int dr, input int dc,
                             input int v0, input int v1, input int v2, input int v3);
`ifndef MOV_SPAWN_EN
        int want[4];
        want = '{v0, v1, v2, v3};
        for (int k = 0; k < 4; k++)
            check_output(name, 64'(cell_at(board_out, r + k * dr, c + k * dc)), 64'(want[k]));
`endif
    endtask

    logic [BW-1:0] b;

    initial begin
        rst = 1'b1; load = 1'b0; start = 1'b0; dir = '0; board_in = '0;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) mb[r][c] = 0;
        step();
        step();
        check_en = 1;
        check_output("reset_board", 64'(board_out), 64'd0);
        check_output("reset_score", 64'(score), 64'd0);
        check_output("reset_busy",  64'(busy),  64'd0);
        check_output("reset_done",  64'(done),  64'd0);
        check_output("reset_moved", 64'(moved), 64'd0);
        rst = 1'b0;
        step();

        // [1,1,1,1] left
        b = '0;
        for (int c = 0; c < 4; c++) b = put(b, 0, c, 1);
        do_load(b);
        apply_stimulus(1);
        check_vec("t1_row0", 0, 0, 0, 1, 2, 2, 0, 0);
        check_output("t1_score", 64'(score), 64'd8);
        check_output("t1_moved", 64'(moved), 64'd1);

        // [1,0,1,2] right, then a none-code move clears moved
        b = '0;
        b = put(b, 0, 0, 1); b = put(b, 0, 2, 1); b = put(b, 0, 3, 2);
        do_load(b);
        apply_stimulus(2);
        check_vec("t2_row0", 0, 0, 0, 1, 0, 0, 2, 2);
        check_output("t2_score", 64'(score), 64'd4);
        check_output("t2_moved", 64'(moved), 64'd1);
        apply_stimulus(0);
        check_output("none_moved", 64'(moved), 64'd0);
        check_output("none_score", 64'(score), 64'd4);

        // column 0 = [2,2,2,0] up, then down
        b = '0;
        for (int r = 0; r < 3; r++) b = put(b, r, 0, 2);
        do_load(b);
        apply_stimulus(3);
        check_vec("t3_up", 0, 0, 1, 0, 3, 2, 0, 0);
        check_output("t3_up_score", 64'(score), 64'd8);
        do_load(b);
        apply_stimulus(4);
        check_vec("t3_down", 0, 0, 1, 0, 0, 0, 2, 3);
        check_output("t3_down_score", 64'(score), 64'd8);

        // no possible change
        b = '0;
        for (int c = 0; c < 4; c++) b = put(b, 0, c, c + 1);
        do_load(b);
        apply_stimulus(1);
        check_vec("t4_row0", 0, 0, 0, 1, 1, 2, 3, 4);
        check_output("t4_moved", 64'(moved), 64'd0);
        check_output("t4_score", 64'(score), 64'd0);

        // max-exponent pair never merges
        b = '0;
        b = put(b, 0, 0, 15); b = put(b, 0, 1, 15);
        do_load(b);
        apply_stimulus(1);
        check_vec("t5_row0", 0, 0, 0, 1, 15, 15, 0, 0);
        check_output("t5_moved", 64'(moved), 64'd0);

        // all-13 board: row0 gives 32768, row1 pushes past 65535
        b = '0;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) b = put(b, r, c, 13);
        do_load(b);
        apply_stimulus(1);
        check_vec("t5_sat_row0", 0, 0, 0, 1, 14, 14, 0, 0);
        check_output("t5_sat_score", 64'(score), 64'hFFFF);
        apply_stimulus(1);
        check_output("t5_sat_hold", 64'(score), 64'hFFFF);

        // reset one cycle after a move is accepted
        start = 1'b1; dir = 3'd1;
        step();
        start = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) mb[r][c] = 0;
        mscore = 0; exp_moved = 0; exp_busy = 0; exp_done = 0;
        check_output("t6_board", 64'(board_out), 64'd0);
        check_output("t6_busy",  64'(busy), 64'd0);
        repeat (N + 3) step();

        // randomized boards and direction codes
        for (int it = 0; it < 48; it++) begin
            if (it % 6 == 0) begin
                b = '0;
                for (int r = 0; r < N; r++)
                    for (int c = 0; c < N; c++) begin
                        int v;
                        v = $urandom_range(0, 9);
                        if (v > 4) v = 0;
                        if ($urandom_range(0, 15) == 0) v = EMAX;
                        b = put(b, r, c, v);
                    end
                do_load(b);
            end
            apply_stimulus($urandom_range(0, 7));
        end

        check_en = 0;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
